// File: rtl/serial_pattern_feeder_if.sv
// Control and serial-stream bundle between a pattern source (master) and the
// serial pattern feeder (slave).
interface serial_pattern_feeder_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
);
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             start;
    logic             step;
    logic             loop;
    logic             abort;
    logic             w_out;
    logic             w_valid;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] bits_left;

    modport master (
        output pattern, len, start, step, loop, abort,
        input  w_out, w_valid, busy, done, bits_left
    );

    modport slave (
        input  pattern, len, start, step, loop, abort,
        output w_out, w_valid, busy, done, bits_left
    );
endinterface

// File: rtl/serial_pattern_feeder.sv
// Parallel-to-serial pattern player: captures a pattern and a length, then
// emits the pattern MSB-first, one bit per step, with optional looping.
module serial_pattern_feeder #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    serial_pattern_feeder_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_eff;

    // Lengths beyond the register width send the whole pattern.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l > WIDTH_L) begin
            return WIDTH_L;
        end
        return l;
    endfunction

    assign len_eff = clamp_len(bus.len);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            pattern_q <= '0;
            len_q     <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        count_d   = count_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (len_eff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        shift_d   = bus.pattern;
                        pattern_d = bus.pattern;
                        len_d     = len_eff;
                        count_d   = len_eff;
                        state_d   = SHIFT;
                    end
                end
            end

            SHIFT: begin
                // Abort wins over step and loop, and a cut-short pass never reports done.
                if (bus.abort) begin
                    state_d = IDLE;
                    shift_d = '0;
                    count_d = '0;
                end else if (bus.step) begin
                    if (count_q > ONE_L) begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        count_d = count_q - ONE_L;
                    end else begin
                        done_d = 1'b1;
                        if (bus.loop) begin
                            shift_d = pattern_q;
                            count_d = len_q;
                        end else begin
                            state_d = IDLE;
                            shift_d = '0;
                            count_d = '0;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.w_out     = shift_q[WIDTH-1];
    assign bus.w_valid   = (state_q == SHIFT) && bus.step;
    assign bus.busy      = (state_q == SHIFT);
    assign bus.done      = done_q;
    assign bus.bits_left = count_q;

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// Directed bench for serial_pattern_feeder: a table of per-cycle vectors plus
// hand-built loop/abort and start-while-busy sequences.
module tb_serial_pattern_feeder;

    typedef struct {
        logic       rn;
        logic       st;
        logic       sp;
        logic       lp;
        logic       ab;
        logic [7:0] pat;
        logic [3:0] len;
        logic       w;
        logic       v;
        logic       b;
        logic       d;
        logic [3:0] bl;
    } vec_t;

    logic clock;
    logic resetn;
    int   total;
    int   bad;
    vec_t tbl[$];

    serial_pattern_feeder_if #(.WIDTH(8), .LEN_W(4)) bus ();

    serial_pattern_feeder #(.WIDTH(8), .LEN_W(4)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    function automatic void add(input logic rn, input logic st, input logic sp, input logic lp,
                                input logic ab, input logic [7:0] pat, input logic [3:0] len,
                                input logic w, input logic v, input logic b, input logic d,
                                input logic [3:0] bl);
        vec_t r;
        r.rn = rn; r.st = st; r.sp = sp; r.lp = lp; r.ab = ab; r.pat = pat; r.len = len;
        r.w = w; r.v = v; r.b = b; r.d = d; r.bl = bl;
        tbl.push_back(r);
    endfunction

    // Drive one cycle's inputs after the falling edge, check just before the rising edge.
    task automatic apply(input vec_t r, input int idx);
        @(negedge clock);
        resetn      = r.rn;
        bus.start   = r.st;
        bus.step    = r.sp;
        bus.loop    = r.lp;
        bus.abort   = r.ab;
        bus.pattern = r.pat;
        bus.len     = r.len;
        #1;
        chk("w_out",     idx, 32'(bus.w_out),     32'(r.w));
        chk("w_valid",   idx, 32'(bus.w_valid),   32'(r.v));
        chk("busy",      idx, 32'(bus.busy),      32'(r.b));
        chk("done",      idx, 32'(bus.done),      32'(r.d));
        chk("bits_left", idx, 32'(bus.bits_left), 32'(r.bl));
    endtask

    initial begin
        vec_t       r;
        logic [7:0] pa;
        logic [7:0] pc;
        total = 0;
        bad   = 0;

        resetn      = 1'b0;
        bus.start   = 1'b0;
        bus.step    = 1'b0;
        bus.loop    = 1'b0;
        bus.abort   = 1'b0;
        bus.pattern = 8'h00;
        bus.len     = 4'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_w_out",     0, 32'(bus.w_out),     0);
        chk("rst_w_valid",   0, 32'(bus.w_valid),   0);
        chk("rst_busy",      0, 32'(bus.busy),      0);
        chk("rst_done",      0, 32'(bus.done),      0);
        chk("rst_bits_left", 0, 32'(bus.bits_left), 0);

        //   rn st sp lp ab pat    len    w v b d bl
        // Basic full pass of 1101_1000.
        pa = 8'b1101_1000;
        add(1, 1, 0, 0, 0, pa, 4'd8,  0, 0, 0, 0, 4'd0);
        for (int k = 0; k < 8; k++)
            add(1, 0, 1, 0, 0, pa, 4'd8, pa[7-k], 1, 1, 0, 4'(8 - k));
        add(1, 0, 1, 0, 0, pa, 4'd8,  0, 0, 0, 1, 4'd0);
        add(1, 0, 0, 0, 0, pa, 4'd8,  0, 0, 0, 0, 4'd0);

        // Three bits of 1010_1111 with stall cycles between steps.
        add(1, 1, 0, 0, 0, 8'hAF, 4'd3, 0, 0, 0, 0, 4'd0);
        add(1, 0, 1, 0, 0, 8'hAF, 4'd3, 1, 1, 1, 0, 4'd3);
        add(1, 0, 0, 0, 0, 8'hAF, 4'd3, 0, 0, 1, 0, 4'd2);
        add(1, 0, 1, 0, 0, 8'hAF, 4'd3, 0, 1, 1, 0, 4'd2);
        add(1, 0, 0, 0, 0, 8'hAF, 4'd3, 1, 0, 1, 0, 4'd1);
        add(1, 0, 1, 0, 0, 8'hAF, 4'd3, 1, 1, 1, 0, 4'd1);
        add(1, 0, 0, 0, 0, 8'hAF, 4'd3, 0, 0, 0, 1, 4'd0);
        add(1, 0, 0, 0, 0, 8'hAF, 4'd3, 0, 0, 0, 0, 4'd0);

        // len=12 clamps to 8 bits of 0110_1001.
        pc = 8'b0110_1001;
        add(1, 1, 0, 0, 0, pc, 4'd12, 0, 0, 0, 0, 4'd0);
        for (int k = 0; k < 8; k++)
            add(1, 0, 1, 0, 0, pc, 4'd12, pc[7-k], 1, 1, 0, 4'(8 - k));
        add(1, 0, 0, 0, 0, pc, 4'd12, 0, 0, 0, 1, 4'd0);

        // len=0: no bits, never busy, single done pulse.
        add(1, 1, 1, 0, 0, 8'hFF, 4'd0, 0, 0, 0, 0, 4'd0);
        add(1, 0, 1, 0, 0, 8'hFF, 4'd0, 0, 0, 0, 1, 4'd0);
        add(1, 0, 1, 0, 0, 8'hFF, 4'd0, 0, 0, 0, 0, 4'd0);

        // start together with abort in IDLE still starts; one-bit pass.
        add(1, 1, 0, 0, 1, 8'h80, 4'd1, 0, 0, 0, 0, 4'd0);
        add(1, 0, 0, 0, 0, 8'h80, 4'd1, 1, 0, 1, 0, 4'd1);
        add(1, 0, 1, 0, 0, 8'h80, 4'd1, 1, 1, 1, 0, 4'd1);
        add(1, 0, 0, 0, 0, 8'h80, 4'd1, 0, 0, 0, 1, 4'd0);
        add(1, 0, 0, 0, 0, 8'h80, 4'd1, 0, 0, 0, 0, 4'd0);

        // Reset after three bits of 1101_0110: no done, outputs cleared.
        add(1, 1, 0, 0, 0, 8'hD6, 4'd8, 0, 0, 0, 0, 4'd0);
        add(1, 0, 1, 0, 0, 8'hD6, 4'd8, 1, 1, 1, 0, 4'd8);
        add(1, 0, 1, 0, 0, 8'hD6, 4'd8, 1, 1, 1, 0, 4'd7);
        add(1, 0, 1, 0, 0, 8'hD6, 4'd8, 0, 1, 1, 0, 4'd6);
        add(0, 0, 1, 0, 0, 8'hD6, 4'd8, 1, 1, 1, 0, 4'd5);
        add(1, 0, 1, 0, 0, 8'hD6, 4'd8, 0, 0, 0, 0, 4'd0);
        add(1, 0, 1, 0, 0, 8'hD6, 4'd8, 0, 0, 0, 0, 4'd0);

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        // Looped two-bit pattern, then abort on the last bit of a pass.
        r = '{rn:1, st:1, sp:1, lp:1, ab:0, pat:8'hC0, len:4'd2,
              w:0, v:0, b:0, d:0, bl:4'd0};
        apply(r, 100);
        for (int k = 1; k <= 8; k++) begin
            r = '{rn:1, st:0, sp:1, lp:1, ab:(k == 8), pat:8'hC0, len:4'd2,
                  w:1, v:1, b:1, d:((k >= 3) && (k % 2 == 1)),
                  bl:((k % 2 == 1) ? 4'd2 : 4'd1)};
            apply(r, 100 + k);
        end
        for (int k = 9; k <= 10; k++) begin
            r = '{rn:1, st:0, sp:1, lp:0, ab:0, pat:8'hC0, len:4'd2,
                  w:0, v:0, b:0, d:0, bl:4'd0};
            apply(r, 100 + k);
        end

        // start pulses with a different pattern while busy are ignored.
        r = '{rn:1, st:1, sp:0, lp:0, ab:0, pat:8'hF0, len:4'd4,
              w:0, v:0, b:0, d:0, bl:4'd0};
        apply(r, 200);
        for (int k = 1; k <= 4; k++) begin
            r = '{rn:1, st:1, sp:1, lp:0, ab:0, pat:8'h0F, len:4'd8,
                  w:1, v:1, b:1, d:0, bl:4'(5 - k)};
            apply(r, 200 + k);
        end
        r = '{rn:1, st:0, sp:0, lp:0, ab:0, pat:8'h0F, len:4'd8,
              w:0, v:0, b:0, d:1, bl:4'd0};
        apply(r, 205);
        r = '{rn:1, st:0, sp:0, lp:0, ab:0, pat:8'h0F, len:4'd8,
              w:0, v:0, b:0, d:0, bl:4'd0};
        apply(r, 206);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
